a2d_arbiter: RTL and testbench

Shares the single A2D interface (one SPI A2D converter front end) between two requesters: the motion controller (IR sensor round robin, port prefix `m_`) and an auxiliary requester such as battery or telemetry sampling (port prefix `a_`). Each requester sees a private copy of the start/complete/result handshake. The arbiter queues one request per requester, grants the converter to one at a time, and routes the result back to the requester that owns the grant. A watchdog stops a missing `cnv_cmplt` from hanging either requester.

---
 rtl/a2d_arbiter.sv | 168 ++++++++++++++++
 tb/tb_a2d_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_arbiter.sv
// Purpose: shares one SPI A2D front end between the motion controller (m_) and an aux requester (a_).
// Latency: request pulse at N -> strt_cnv at N+2; cnv_cmplt at M -> x_cnv_cmplt/x_res at M+1.
// Backpressure: one queued request per requester; a pulse while that requester is pending is dropped.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   m_strt_cnv, m_chnnl             motion request pulse + channel
//   m_cnv_cmplt, m_res              motion completion pulse + held result
//   a_strt_cnv, a_chnnl             aux request pulse + channel
//   a_cnv_cmplt, a_res              aux completion pulse + held result
//   strt_cnv, chnnl                 start pulse + channel to the A2D interface
//   cnv_cmplt, A2D_res              conversion done + result from the A2D interface
//   busy, timeout_err               ISSUE/WAIT indicator, sticky watchdog flag
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise fixed
// priority (motion first) with a starvation guard of STARVE_MAX motion grants.
module a2d_arbiter #(
  parameter int TIMEOUT_CYC = 4095,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_strt_cnv,
  input  logic [2:0]  m_chnnl,
  output logic        m_cnv_cmplt,
  output logic [11:0] m_res,
  input  logic        a_strt_cnv,
  input  logic [2:0]  a_chnnl,
  output logic        a_cnv_cmplt,
  output logic [11:0] a_res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        m_pend, a_pend;
  logic [2:0]  m_ch, a_ch;
  logic        gnt;            // 0 = motion owns the converter, 1 = aux
  logic [11:0] wd_cnt;
  logic        grant_fire, grant_aux, done_ok, done_to;

`ifdef ARB_RR_EN
  logic last_gnt;
`else
  localparam int SW = $clog2(STARVE_MAX + 2);
  logic [SW-1:0] starve_cnt;
`endif

  // Winner if a grant is made this cycle.
  always_comb begin
`ifdef ARB_RR_EN
    // On a tie the requester that did not win last time goes next.
    grant_aux = a_pend && (!m_pend || !last_gnt);
`else
    grant_aux = a_pend && (!m_pend || (starve_cnt == SW'(STARVE_MAX)));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (m_pend || a_pend) begin
          grant_fire = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A completion in the same cycle as the timeout takes precedence.
        if (cnv_cmplt) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end else if (wd_cnt == 12'(TIMEOUT_CYC)) begin
          done_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pulses decoded from the registered state are one cycle wide by construction.
  assign strt_cnv    = (state == ISSUE);
  assign busy        = (state == ISSUE) || (state == WAIT);
  assign m_cnv_cmplt = (state == RESP) && !gnt;
  assign a_cnv_cmplt = (state == RESP) && gnt;

  // Depth-1 request queues. The pending flag clears at grant, so a requester
  // can queue its next request while the current one is still in service.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      a_pend <= 1'b0;
      m_ch   <= 3'd0;
      a_ch   <= 3'd0;
    end else begin
      if (grant_fire && !grant_aux) m_pend <= 1'b0;
      if (grant_fire && grant_aux)  a_pend <= 1'b0;
      if (m_strt_cnv && !m_pend) begin
        m_pend <= 1'b1;
        m_ch   <= m_chnnl;
      end
      if (a_strt_cnv && !a_pend) begin
        a_pend <= 1'b1;
        a_ch   <= a_chnnl;
      end
    end
  end

  // Fairness bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef ARB_RR_EN
      last_gnt <= 1'b1;
`else
      starve_cnt <= '0;
`endif
    end else if (grant_fire) begin
`ifdef ARB_RR_EN
      last_gnt <= grant_aux;
`else
      if (grant_aux)   starve_cnt <= '0;
      else if (a_pend) starve_cnt <= starve_cnt + SW'(1);
`endif
    end
  end

  // Grant, channel, watchdog and result datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= 1'b0;
      chnnl       <= 3'd0;
      wd_cnt      <= 12'd0;
      m_res       <= 12'h000;
      a_res       <= 12'h000;
      timeout_err <= 1'b0;
    end else begin
      if (grant_fire) begin
        gnt   <= grant_aux;
        chnnl <= grant_aux ? a_ch : m_ch;
      end
      if (state == ISSUE)     wd_cnt <= 12'd0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 12'd1;
      // An aborted conversion hands the owner a zero result.
      if (done_ok || done_to) begin
        if (gnt) a_res <= done_ok ? A2D_res : 12'h000;
        else     m_res <= done_ok ? A2D_res : 12'h000;
      end
      if (done_to) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Purpose: randomized + directed scoreboard bench for a2d_arbiter.
// The reference model tracks pending requests and a service timeline per
// conversion; a separate monitor pops expected start/completion events.
module tb_a2d_arbiter;

  localparam int TO   = 16;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m_strt_cnv = 1'b0;
  logic [2:0]  m_chnnl = 3'd0;
  logic        a_strt_cnv = 1'b0;
  logic [2:0]  a_chnnl = 3'd0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] A2D_res = 12'h000;
  logic        m_cnv_cmplt, a_cnv_cmplt, strt_cnv, busy, timeout_err;
  logic [11:0] m_res, a_res;
  logic [2:0]  chnnl;

  a2d_arbiter #(.TIMEOUT_CYC(TO), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_strt_cnv(m_strt_cnv), .m_chnnl(m_chnnl), .m_cnv_cmplt(m_cnv_cmplt), .m_res(m_res),
    .a_strt_cnv(a_strt_cnv), .a_chnnl(a_chnnl), .a_cnv_cmplt(a_cnv_cmplt), .a_res(a_res),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [2:0] ch; } iss_t;
  typedef struct { int cyc; bit aux; logic [11:0] res; } cmp_t;
  iss_t iss_q[$];
  cmp_t cmp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          mp, ap, last_aux, in_rst = 1'b1;
  logic [2:0]  mch, ach, ch_hold;
  logic [11:0] m_hold, a_hold, cmplt_res, next_res;
  int          starve, free_at, busy_lo, busy_hi, err_at, wait_lo, wait_hi, cmplt_at;
  int          next_delay;   // cycles from strt_cnv to cnv_cmplt; <= 0 means never

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    mp = 0; ap = 0; mch = 0; ach = 0; starve = 0; last_aux = 1;
    free_at = 0; busy_lo = 0; busy_hi = -1; err_at = -1;
    wait_lo = 0; wait_hi = -1; cmplt_at = -1;
    m_hold = 0; a_hold = 0; ch_hold = 0;
    iss_q.delete(); cmp_q.delete();
  endtask

  // One clock cycle of stimulus plus the model's view of that cycle.
  task automatic step(input bit mq, input logic [2:0] mc, input bit aq, input logic [2:0] ac,
                      input bit spur);
    int   c;
    bit   gm, ga;
    iss_t ie;
    cmp_t ce;
    @(negedge clk); #1;
    c = cyc;
    gm = 0; ga = 0;
    if (c >= free_at && (mp || ap)) begin
`ifdef ARB_RR_EN
      ga = ap && (!mp || !last_aux);
      last_aux = ga;
`else
      ga = ap && (!mp || starve == SMAX);
      if (ga) starve = 0;
      else if (ap) starve++;
`endif
      gm = !ga;
      ie.cyc = c + 1;
      ie.ch  = ga ? ach : mch;
      iss_q.push_back(ie);
      ce.aux  = ga;
      wait_lo = c + 2;
      if (next_delay > 0) begin
        cmplt_at  = c + 1 + next_delay;
        cmplt_res = next_res;
        wait_hi   = cmplt_at;
        ce.cyc    = cmplt_at + 1;
        ce.res    = next_res;
      end else begin
        cmplt_at = -1;
        wait_hi  = c + TO + 2;
        ce.cyc   = c + TO + 3;
        ce.res   = 12'h000;
        if (err_at < 0) err_at = ce.cyc;
      end
      cmp_q.push_back(ce);
      busy_lo = c + 1;
      busy_hi = ce.cyc - 1;
      free_at = ce.cyc + 1;
    end
    if (mq && !mp) mch = mc;
    if (aq && !ap) ach = ac;
    mp = (mp && !gm) || (mq && !mp);
    ap = (ap && !ga) || (aq && !ap);
    m_strt_cnv = mq; m_chnnl = mc;
    a_strt_cnv = aq; a_chnnl = ac;
    if (c == cmplt_at) begin
      cnv_cmplt = 1'b1; A2D_res = cmplt_res;
    end else if (spur && !(c >= wait_lo && c <= wait_hi)) begin
      cnv_cmplt = 1'b1; A2D_res = 12'($urandom);
    end else begin
      cnv_cmplt = 1'b0; A2D_res = 12'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 0, 3'd0, 0);
  endtask

  task automatic apply_reset();
    in_rst = 1;
    rst_n = 1'b0;
    m_strt_cnv = 0; a_strt_cnv = 0; cnv_cmplt = 0;
    #1;
    chk("rst_strt_cnv",    32'(strt_cnv),    32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    chk("rst_m_cnv_cmplt", 32'(m_cnv_cmplt), 32'd0);
    chk("rst_a_cnv_cmplt", 32'(a_cnv_cmplt), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_chnnl",       32'(chnnl),       32'd0);
    chk("rst_m_res",       32'(m_res),       32'd0);
    chk("rst_a_res",       32'(a_res),       32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    in_rst = 0;
  endtask

  // Monitor: compares DUT events against the scoreboard queues.
  initial begin
    iss_t ie;
    cmp_t ce;
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        if (strt_cnv) begin
          if (iss_q.size() == 0) chk("strt_unexpected", 32'(strt_cnv), 32'd0);
          else begin
            ie = iss_q.pop_front();
            chk("strt_cycle", 32'(cyc), 32'(ie.cyc));
            chk("strt_chnnl", 32'(chnnl), 32'(ie.ch));
            ch_hold = ie.ch;
          end
        end else if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
          chk("strt_missing", 32'(strt_cnv), 32'd1);
          ie = iss_q.pop_front();
        end
        if (m_cnv_cmplt || a_cnv_cmplt) begin
          if (cmp_q.size() == 0) chk("cmplt_unexpected", 32'({m_cnv_cmplt, a_cnv_cmplt}), 32'd0);
          else begin
            ce = cmp_q.pop_front();
            chk("cmplt_cycle", 32'(cyc), 32'(ce.cyc));
            chk("cmplt_who", 32'({m_cnv_cmplt, a_cnv_cmplt}), ce.aux ? 32'd1 : 32'd2);
            if (ce.aux) a_hold = ce.res;
            else        m_hold = ce.res;
          end
        end else if (cmp_q.size() > 0 && cmp_q[0].cyc <= cyc) begin
          ce = cmp_q.pop_front();
          chk("cmplt_missing", 32'({m_cnv_cmplt, a_cnv_cmplt}), ce.aux ? 32'd1 : 32'd2);
        end
        chk("m_res",       32'(m_res),       32'(m_hold));
        chk("a_res",       32'(a_res),       32'(a_hold));
        chk("chnnl_hold",  32'(chnnl),       32'(ch_hold));
        chk("busy",        32'(busy),        32'(cyc >= busy_lo && cyc <= busy_hi));
        chk("timeout_err", 32'(timeout_err), 32'(err_at >= 0 && cyc >= err_at));
      end
    end
  end

  initial begin
    int r;
    next_delay = 3; next_res = 12'h123;
    model_clear();
    #2;
    apply_reset();

    // Motion only: strt two cycles after the pulse, result 8 cycles after strt.
    idle(6);
    next_delay = 8; next_res = 12'hA5C;
    step(1, 3'b100, 0, 3'd0, 0);
    idle(14);

    // Simultaneous requests.
    next_delay = 3; next_res = 12'h3C1;
    step(1, 3'd1, 1, 3'd6, 0);
    idle(5);
    next_res = 12'h9E7;
    idle(10);

    // Starvation guard: aux held pending while motion re-requests every cycle.
    next_delay = 2;
    for (int i = 0; i < 60; i++) begin
      next_res = 12'($urandom);
      step(1, 3'(i), (i == 0 || i == 30), 3'd5, 0);
    end
    idle(10);

    // Drop (second pulse while pending) and overlap (new pulse during WAIT).
    next_delay = 6; next_res = 12'h0F0;
    step(1, 3'd2, 0, 3'd0, 0);
    step(1, 3'd7, 0, 3'd0, 0);
    idle(3);
    next_res = 12'h0F1;
    step(1, 3'd3, 0, 3'd0, 0);
    idle(20);

    // Timeout on aux, then a normal request, then completion on the timeout cycle.
    next_delay = -1;
    step(0, 3'd0, 1, 3'd4, 1);
    for (int i = 0; i < TO + 4; i++) step(0, 3'd0, 0, 3'd0, 1);
    next_delay = 4; next_res = 12'h5A5;
    step(0, 3'd0, 1, 3'd3, 0);
    idle(10);
    next_delay = TO + 1; next_res = 12'h777;
    step(1, 3'd6, 0, 3'd0, 0);
    idle(TO + 6);

    // Back-to-back simultaneous requests (alternation under round robin).
    next_delay = 1;
    for (int i = 0; i < 30; i++) begin
      next_res = 12'($urandom);
      step(1, 3'd1, 1, 3'd2, 0);
    end
    idle(10);

    // Reset during WAIT, then stray completions while idle.
    next_delay = 12; next_res = 12'hBEE;
    step(1, 3'd5, 0, 3'd0, 0);
    idle(5);
    @(negedge clk); #1;
    apply_reset();
    for (int i = 0; i < 4; i++) step(0, 3'd0, 0, 3'd0, 1);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       next_delay = -1;
      else if (r < 8)  next_delay = TO + 1;
      else if (r < 12) next_delay = TO;
      else             next_delay = $urandom_range(1, 6);
      next_res = 12'($urandom);
      step($urandom_range(0, 99) < 35, 3'($urandom), $urandom_range(0, 99) < 25, 3'($urandom),
           $urandom_range(0, 9) == 0);
    end
    idle(TO + 20);
    chk("iss_q_drained", 32'(iss_q.size()), 32'd0);
    chk("cmp_q_drained", 32'(cmp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
